tile_interact_engine: RTL and testbench

- Sequential successor to the combinational per-tile interaction mux.
- Accepts one-step move requests and computes the target coordinate with bounds check.
- Reads the target tile from the map RAM (1-cycle read latency), resolves wall, key, door, monster and potion rules, then writes back the tile and updates player state.
- Generalised over map size, key colour count, key counter width and combat/heal values. Sits between the keyboard move decoder and the map RAM / renderer.

---
 rtl/tile_interact_engine_pkg.sv | 55 +++++
 rtl/tile_interact_engine_classify.sv | 35 +++
 rtl/tile_interact_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_tile_interact_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_interact_engine_pkg.sv
// Shared tile ids, result codes, FSM states and pending-outcome payload for the
// tile interaction engine and its tile classifier.
package tile_interact_engine_pkg;

   localparam int unsigned TILE_GROUND     = 0;
   localparam int unsigned TILE_WALL_LO    = 1;
   localparam int unsigned TILE_WALL_HI    = 7;
   localparam int unsigned TILE_KEY_BASE   = 16;
   localparam int unsigned TILE_DOOR_BASE  = 32;
   localparam int unsigned TILE_MONSTER_LO = 48;
   localparam int unsigned TILE_MONSTER_HI = 55;
   localparam int unsigned TILE_POTION     = 64;

   localparam int unsigned RESULT_W = 3;

   typedef enum logic [2:0] {
      TC_OTHER,
      TC_WALL,
      TC_KEY,
      TC_DOOR,
      TC_MONSTER,
      TC_POTION
   } tile_class_e;

   typedef enum logic [RESULT_W-1:0] {
      RES_MOVED         = 3'd0,
      RES_OOB           = 3'd1,
      RES_WALL          = 3'd2,
      RES_DOOR_LOCKED   = 3'd3,
      RES_MONSTER_BLOCK = 3'd4,
      RES_KEY_TAKEN     = 3'd5,
      RES_DOOR_OPENED   = 3'd6,
      RES_FOUGHT        = 3'd7
   } result_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESOLVE,
      ST_WRITE,
      ST_FINISH
   } state_e;

   // Outcome decided in RESOLVE and committed in FINISH.
   typedef struct packed {
      result_e res;
      logic    move;
   } outcome_t;

   // Colour index width; never zero so a single-colour build stays legal.
   function automatic int unsigned color_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_interact_engine_classify.sv
// Combinational tile id -> class and colour index; shared with the renderer.
module tile_classify
   import tile_interact_engine_pkg::*;
#(
   parameter int unsigned TILE_W    = 16,
   parameter int unsigned KEY_TYPES = 3,
   parameter int unsigned COLOR_W   = color_width(KEY_TYPES)
) (
   input  logic [TILE_W-1:0]  i_tile,
   output tile_class_e        o_class_c,
   output logic [COLOR_W-1:0] o_color_c
);

   always_comb begin
      o_class_c = TC_OTHER;
      o_color_c = '0;
      if (i_tile >= TILE_W'(TILE_WALL_LO) && i_tile <= TILE_W'(TILE_WALL_HI)) begin
         o_class_c = TC_WALL;
      end else if (i_tile >= TILE_W'(TILE_KEY_BASE) &&
                   i_tile <  TILE_W'(TILE_KEY_BASE + KEY_TYPES)) begin
         o_class_c = TC_KEY;
         o_color_c = COLOR_W'(i_tile - TILE_W'(TILE_KEY_BASE));
      end else if (i_tile >= TILE_W'(TILE_DOOR_BASE) &&
                   i_tile <  TILE_W'(TILE_DOOR_BASE + KEY_TYPES)) begin
         o_class_c = TC_DOOR;
         o_color_c = COLOR_W'(i_tile - TILE_W'(TILE_DOOR_BASE));
      end else if (i_tile >= TILE_W'(TILE_MONSTER_LO) &&
                   i_tile <= TILE_W'(TILE_MONSTER_HI)) begin
         o_class_c = TC_MONSTER;
      end else if (i_tile == TILE_W'(TILE_POTION)) begin
         o_class_c = TC_POTION;
      end
   end

endmodule

// File: rtl/tile_interact_engine.sv
// Sequential move engine: bounds-checks a one-step move, reads the target tile,
// applies wall/key/door/monster/potion rules, writes back and commits player state.
module tile_interact_engine
   import tile_interact_engine_pkg::*;
#(
   parameter int unsigned MAP_W       = 16,
   parameter int unsigned MAP_H       = 16,
   parameter int unsigned COORD_W     = 4,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TILE_W      = 16,
   parameter int unsigned KEY_TYPES   = 3,
   parameter int unsigned KEY_W       = 4,
   parameter int unsigned HEALTH_W    = 8,
   parameter int unsigned HEALTH_INIT = 100,
   parameter int unsigned HEALTH_MAX  = 200,
   parameter int unsigned DAMAGE      = 3,
   parameter int unsigned HEAL        = 10,
   parameter int unsigned START_X     = 1,
   parameter int unsigned START_Y     = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_move_valid,
   input  logic [1:0]                   i_move_dir,
   output logic                         o_ready,
   output logic                         o_done,
   output logic [RESULT_W-1:0]          o_result,
   output logic [ADDR_W-1:0]            o_map_rd_addr,
   input  logic [TILE_W-1:0]            i_map_rd_data,
   output logic                         o_map_wr_en,
   output logic [ADDR_W-1:0]            o_map_wr_addr,
   output logic [TILE_W-1:0]            o_map_wr_data,
   output logic [COORD_W-1:0]           o_player_x,
   output logic [COORD_W-1:0]           o_player_y,
   output logic [KEY_TYPES*KEY_W-1:0]   o_key_count,
   output logic [HEALTH_W-1:0]          o_health
);

   localparam int unsigned COLOR_W = color_width(KEY_TYPES);
   localparam int unsigned CXW     = COORD_W + 1;
   localparam int unsigned KW1     = KEY_W + 1;
   localparam int unsigned HW1     = HEALTH_W + 1;
   localparam int unsigned KEY_MAX = (1 << KEY_W) - 1;

   state_e                       r_state;
   logic [COORD_W-1:0]           r_tx;
   logic [COORD_W-1:0]           r_ty;
   outcome_t                     r_pend;
   logic [KEY_TYPES*KEY_W-1:0]   r_key_nx;
   logic [HEALTH_W-1:0]          r_health_nx;

   logic [COORD_W-1:0]           w_tx;
   logic [COORD_W-1:0]           w_ty;
   logic                         w_oob;
   logic [ADDR_W-1:0]            w_addr;

   tile_class_e                  w_class;
   logic [COLOR_W-1:0]           w_color;
   int unsigned                  w_kbase;
   logic [KEY_W-1:0]             w_key_cur;
   logic [KW1-1:0]               w_key_wide;
   logic [KEY_W-1:0]             w_key_inc;
   logic [HW1-1:0]               w_heal_wide;
   logic [HEALTH_W-1:0]          w_health_heal;

   result_e                      w_res;
   logic                         w_move;
   logic                         w_write;
   logic [KEY_TYPES*KEY_W-1:0]   w_key_nx;
   logic [HEALTH_W-1:0]          w_health_nx;

   tile_classify #(
      .TILE_W    (TILE_W),
      .KEY_TYPES (KEY_TYPES),
      .COLOR_W   (COLOR_W)
   ) u_classify (
      .i_tile    (i_map_rd_data),
      .o_class_c (w_class),
      .o_color_c (w_color)
   );

   // Target coordinate and bounds check, widened so the upper edge never wraps.
   always_comb begin
      w_tx  = o_player_x;
      w_ty  = o_player_y;
      w_oob = 1'b0;
      case (i_move_dir)
         2'd0: if (o_player_y == '0) w_oob = 1'b1;
               else w_ty = o_player_y - COORD_W'(1);
         2'd1: if (CXW'(o_player_y) + CXW'(1) >= CXW'(MAP_H)) w_oob = 1'b1;
               else w_ty = o_player_y + COORD_W'(1);
         2'd2: if (o_player_x == '0) w_oob = 1'b1;
               else w_tx = o_player_x - COORD_W'(1);
         2'd3: if (CXW'(o_player_x) + CXW'(1) >= CXW'(MAP_W)) w_oob = 1'b1;
               else w_tx = o_player_x + COORD_W'(1);
      endcase
      w_addr = ADDR_W'(w_ty) * ADDR_W'(MAP_W) + ADDR_W'(w_tx);
   end

   // Saturating key increment and potion heal on widened intermediates.
   always_comb begin
      w_kbase       = 32'(w_color) * KEY_W;
      w_key_cur     = o_key_count[w_kbase +: KEY_W];
      w_key_wide    = KW1'(w_key_cur) + KW1'(1);
      w_key_inc     = (w_key_wide > KW1'(KEY_MAX)) ? KEY_W'(KEY_MAX) : w_key_wide[KEY_W-1:0];
      w_heal_wide   = HW1'(o_health) + HW1'(HEAL);
      w_health_heal = (w_heal_wide > HW1'(HEALTH_MAX)) ? HEALTH_W'(HEALTH_MAX)
                                                        : w_heal_wide[HEALTH_W-1:0];
   end

   // Tile rule resolution; only meaningful while in RESOLVE.
   always_comb begin
      w_res       = RES_MOVED;
      w_move      = 1'b1;
      w_write     = 1'b0;
      w_key_nx    = o_key_count;
      w_health_nx = o_health;
      case (w_class)
         TC_WALL: begin
            w_res  = RES_WALL;
            w_move = 1'b0;
         end
         TC_KEY: begin
            w_key_nx[w_kbase +: KEY_W] = w_key_inc;
            w_write = 1'b1;
            w_res   = RES_KEY_TAKEN;
         end
         TC_DOOR: begin
            if (w_key_cur == '0) begin
               w_res  = RES_DOOR_LOCKED;
               w_move = 1'b0;
            end else begin
               w_key_nx[w_kbase +: KEY_W] = w_key_cur - KEY_W'(1);
               w_write = 1'b1;
               w_res   = RES_DOOR_OPENED;
            end
         end
         TC_MONSTER: begin
            if (o_health > HEALTH_W'(DAMAGE)) begin
               w_health_nx = o_health - HEALTH_W'(DAMAGE);
               w_write     = 1'b1;
               w_res       = RES_FOUGHT;
            end else begin
               w_res  = RES_MONSTER_BLOCK;
               w_move = 1'b0;
            end
         end
         TC_POTION: begin
            w_health_nx = w_health_heal;
            w_write     = 1'b1;
            w_res       = RES_FOUGHT;
         end
         default: ;
      endcase
   end

   // Move FSM with registered outputs; player state commits only in FINISH.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_tx          <= '0;
         r_ty          <= '0;
         r_pend        <= '0;
         r_key_nx      <= '0;
         r_health_nx   <= HEALTH_W'(HEALTH_INIT);
         o_ready       <= 1'b1;
         o_done        <= 1'b0;
         o_result      <= '0;
         o_map_rd_addr <= '0;
         o_map_wr_en   <= 1'b0;
         o_map_wr_addr <= '0;
         o_map_wr_data <= '0;
         o_player_x    <= COORD_W'(START_X);
         o_player_y    <= COORD_W'(START_Y);
         o_key_count   <= '0;
         o_health      <= HEALTH_W'(HEALTH_INIT);
      end else begin
         o_done      <= 1'b0;
         o_map_wr_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_move_valid) begin
                  r_tx    <= w_tx;
                  r_ty    <= w_ty;
                  o_ready <= 1'b0;
                  if (w_oob) begin
                     r_pend      <= '{res: RES_OOB, move: 1'b0};
                     r_key_nx    <= o_key_count;
                     r_health_nx <= o_health;
                     r_state     <= ST_FINISH;
                  end else begin
                     o_map_rd_addr <= w_addr;
                     r_state       <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: r_state <= ST_RESOLVE;
            ST_RESOLVE: begin
               r_pend      <= '{res: w_res, move: w_move};
               r_key_nx    <= w_key_nx;
               r_health_nx <= w_health_nx;
               if (w_write) begin
                  o_map_wr_en   <= 1'b1;
                  o_map_wr_addr <= o_map_rd_addr;
                  o_map_wr_data <= TILE_W'(TILE_GROUND);
                  r_state       <= ST_WRITE;
               end else begin
                  r_state <= ST_FINISH;
               end
            end
            ST_WRITE: r_state <= ST_FINISH;
            ST_FINISH: begin
               o_done   <= 1'b1;
               o_result <= r_pend.res;
               if (r_pend.move) begin
                  o_player_x <= r_tx;
                  o_player_y <= r_ty;
               end
               o_key_count <= r_key_nx;
               o_health    <= r_health_nx;
               o_ready     <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_interact_engine.sv
// Bench for tile_interact_engine: map RAM, rule-level reference model and
// per-cycle output compare, directed scenarios then randomized moves.
module tb_tile_interact_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mv;
   logic [1:0]  dir;
   logic        ready, done, wr_en;
   logic [2:0]  result;
   logic [7:0]  rd_addr, wr_addr;
   logic [15:0] rd_q, wr_data;
   logic [3:0]  px, py;
   logic [11:0] kc;
   logic [7:0]  health;

   always #5 clk = ~clk;

   tile_interact_engine dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_move_valid  (mv),
      .i_move_dir    (dir),
      .o_ready       (ready),
      .o_done        (done),
      .o_result      (result),
      .o_map_rd_addr (rd_addr),
      .i_map_rd_data (rd_q),
      .o_map_wr_en   (wr_en),
      .o_map_wr_addr (wr_addr),
      .o_map_wr_data (wr_data),
      .o_player_x    (px),
      .o_player_y    (py),
      .o_key_count   (kc),
      .o_health      (health)
   );

   // Map RAM seen by the DUT (1-cycle read); contents written only by the main process.
   logic [15:0] mem [256];
   always @(posedge clk) rd_q <= mem[rd_addr];

   int cyc = 0, n_checks = 0, n_fail = 0;
   int m_map [256];
   int m_x, m_y, m_h, m_res, m_rd_addr, m_acc, m_done_cyc;
   int m_keys [3];
   bit m_busy, m_oob;
   int p_x, p_y, p_h, p_res, p_addr;
   int p_keys [3];
   bit p_wr;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic int keys_packed();
      return m_keys[0] + m_keys[1] * 16 + m_keys[2] * 256;
   endfunction

   task automatic model_reset();
      m_x = 1; m_y = 1; m_h = 100; m_res = 0; m_rd_addr = 0;
      m_keys = '{0, 0, 0};
      m_busy = 1'b0;
   endtask

   task automatic model_accept(input int d);
      int tx, ty, t, k;
      bit mvok;
      tx = m_x; ty = m_y;
      case (d)
         0: ty = ty - 1;
         1: ty = ty + 1;
         2: tx = tx - 1;
         default: tx = tx + 1;
      endcase
      p_x = m_x; p_y = m_y; p_h = m_h; p_keys = m_keys; p_wr = 1'b0; p_addr = 0;
      m_oob = (tx < 0 || tx > 15 || ty < 0 || ty > 15);
      if (m_oob) p_res = 1;
      else begin
         p_addr = ty * 16 + tx;
         t = m_map[p_addr];
         p_res = 0; mvok = 1'b1;
         if (t >= 1 && t <= 7) begin p_res = 2; mvok = 1'b0; end
         else if (t >= 16 && t <= 18) begin
            k = t - 16;
            if (p_keys[k] < 15) p_keys[k] = p_keys[k] + 1;
            p_wr = 1'b1; p_res = 5;
         end else if (t >= 32 && t <= 34) begin
            k = t - 32;
            if (p_keys[k] == 0) begin p_res = 3; mvok = 1'b0; end
            else begin p_keys[k] = p_keys[k] - 1; p_wr = 1'b1; p_res = 6; end
         end else if (t >= 48 && t <= 55) begin
            if (p_h > 3) begin p_h = p_h - 3; p_wr = 1'b1; p_res = 7; end
            else begin p_res = 4; mvok = 1'b0; end
         end else if (t == 64) begin
            p_h = (p_h + 10 > 200) ? 200 : p_h + 10;
            p_wr = 1'b1; p_res = 7;
         end
         if (mvok) begin p_x = tx; p_y = ty; end
      end
      m_busy = 1'b1;
      m_acc = cyc;
      m_done_cyc = cyc + (m_oob ? 2 : (p_wr ? 5 : 4));
   endtask

   task automatic check_cycle();
      bit ew, ed;
      if (wr_en) mem[wr_addr] = wr_data;
      ew = m_busy && p_wr && (cyc == m_acc + 3);
      chk("wr_en", int'(wr_en), int'(ew));
      if (ew) begin
         chk("wr_addr", int'(wr_addr), p_addr);
         chk("wr_data", int'(wr_data), 0);
      end
      if (m_busy && !m_oob && cyc == m_acc + 1) m_rd_addr = p_addr;
      chk("rd_addr", int'(rd_addr), m_rd_addr);
      ed = m_busy && (cyc == m_done_cyc);
      chk("done", int'(done), int'(ed));
      if (ed) begin
         m_x = p_x; m_y = p_y; m_h = p_h; m_keys = p_keys; m_res = p_res;
         if (p_wr) m_map[p_addr] = 0;
         m_busy = 1'b0;
      end
      chk("ready", int'(ready), int'(!m_busy));
      chk("result", int'(result), m_res);
      chk("player_x", int'(px), m_x);
      chk("player_y", int'(py), m_y);
      chk("key_count", int'(kc), keys_packed());
      chk("health", int'(health), m_h);
   endtask

   task automatic tick(input bit v, input int d, input bit r);
      @(negedge clk);
      cyc++;
      check_cycle();
      rst_n = r;
      mv = v;
      dir = 2'(d);
      if (!r) model_reset();
      else if (v && !m_busy) model_accept(d);
   endtask

   task automatic set_tile(input int x, input int y, input int t);
      mem[y * 16 + x] = 16'(t);
      m_map[y * 16 + x] = t;
   endtask

   task automatic do_move(input int d);
      tick(1'b1, d, 1'b1);
      for (int i = 0; i < 12 && m_busy; i++) tick(1'b0, 0, 1'b1);
      chk("move_timeout", int'(m_busy), 0);
   endtask

   // Serpentine walk that places the given tile on the target square first.
   task automatic auto_move(input int tile);
      int d, tx, ty;
      if (m_y % 2 == 0) d = (m_x < 15) ? 3 : ((m_y < 15) ? 1 : 0);
      else              d = (m_x > 0)  ? 2 : ((m_y < 15) ? 1 : 0);
      tx = m_x + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
      ty = m_y + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
      set_tile(tx, ty, tile);
      do_move(d);
   endtask

   function automatic int pick_tile();
      case ($urandom_range(0, 11))
         0, 1, 2: return 0;
         3:       return int'($urandom_range(1, 7));
         4:       return 16 + int'($urandom_range(0, 2));
         5:       return 32 + int'($urandom_range(0, 2));
         6, 7:    return 48 + int'($urandom_range(0, 7));
         8:       return 64;
         9:       return 99;
         10:      return 35;
         default: return 19;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; mv = 1'b0; dir = 2'd0;
      for (int i = 0; i < 256; i++) set_tile(i % 16, i / 16, 0);
      model_reset();
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b1);
      chk("lit_rst_x", int'(px), 1);
      chk("lit_rst_y", int'(py), 1);
      chk("lit_rst_health", int'(health), 100);
      chk("lit_rst_ready", int'(ready), 1);

      // Ground move right.
      do_move(3);
      chk("lit_ground_res", int'(result), 0);
      chk("lit_ground_x", int'(px), 2);

      // Walk to (0,5) and bump the left edge.
      do_move(2); do_move(2);
      for (int i = 0; i < 4; i++) do_move(1);
      do_move(2);
      chk("lit_oob_res", int'(result), 1);
      chk("lit_oob_x", int'(px), 0);
      chk("lit_oob_y", int'(py), 5);

      // Colour-2 keys up to and past saturation.
      auto_move(18);
      chk("lit_key_res", int'(result), 5);
      chk("lit_key2_one", int'(kc[11:8]), 1);
      for (int i = 0; i < 15; i++) auto_move(18);
      chk("lit_key2_sat", int'(kc[11:8]), 15);

      // Colour-1 door locked, then opened with one key.
      auto_move(33);
      chk("lit_door_locked", int'(result), 3);
      auto_move(17);
      auto_move(33);
      chk("lit_door_open", int'(result), 6);
      chk("lit_key1_zero", int'(kc[7:4]), 0);

      // Combat down to the block threshold, then potions to the cap.
      for (int i = 0; i < 32; i++) auto_move(48 + (i % 8));
      chk("lit_health4", int'(health), 4);
      auto_move(50);
      chk("lit_fight_res", int'(result), 7);
      chk("lit_health1", int'(health), 1);
      auto_move(55);
      chk("lit_mon_block", int'(result), 4);
      chk("lit_health1_hold", int'(health), 1);
      for (int i = 0; i < 19; i++) auto_move(64);
      auto_move(48); auto_move(48);
      auto_move(64);
      chk("lit_health195", int'(health), 195);
      auto_move(64);
      chk("lit_health_cap", int'(health), 200);

      // Reset while waiting on a key read: the write must be dropped.
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b1);
      set_tile(2, 1, 16);
      tick(1'b1, 3, 1'b1);
      tick(1'b1, 0, 1'b0);
      tick(1'b0, 2, 1'b0);
      tick(1'b1, 1, 1'b0);
      tick(1'b0, 0, 1'b1);
      chk("lit_mid_rst_x", int'(px), 1);
      chk("lit_mid_rst_health", int'(health), 100);
      chk("lit_mid_rst_keys", int'(kc), 0);
      chk("lit_mid_rst_wr", int'(wr_en), 0);
      do_move(3);
      chk("lit_after_rst_res", int'(result), 5);
      chk("lit_after_rst_key0", int'(kc[3:0]), 1);

      // Randomized map and move traffic with occasional resets.
      for (int i = 0; i < 256; i++) set_tile(i % 16, i / 16, pick_tile());
      for (int i = 0; i < 1500; i++)
         tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
              $urandom_range(0, 99) != 0);
      for (int i = 0; i < 12 && m_busy; i++) tick(1'b0, 0, 1'b1);
      chk("drain_timeout", int'(m_busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
